// File: rtl/cmd_pkg.sv
// Shared definitions for the UART command-frame path: FSM encoding and frame geometry.
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    localparam int         CMD_BYTES  = 6;
    localparam logic [7:0] HEADER_DEF = 8'hAA;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte stall counter: synchronous clear has priority over enable; tc_o flags the last allowed idle cycle.
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Assembles HEADER + 6 payload bytes + checksum from a UART byte stream and drives the
// instruction decomposer's 48-bit bus with a HOLD_CYC-long enable per accepted frame.
module cmd_frame_ctrl
    import cmd_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEF,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         HOLD_CYC    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [47:0] cmd_data,
    output logic        cmd_en,
    output logic        cmd_strobe,
    output logic        busy,
    output logic        err_chk,
    output logic        err_timeout,
    output logic [7:0]  frame_cnt
);

    state_e      state_q, state_d;
    logic [47:0] payload_q, payload_d;
    logic [47:0] cmd_data_q, cmd_data_d;
    logic [7:0]  sum_q, sum_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        cmd_en_q, cmd_en_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;
    logic        err_chk_q, err_chk_d;
    logic        err_to_q, err_to_d;

    logic        in_frame;
    logic        to_tc;

    // Stall timer only runs while a frame is partially received; any byte restarts it.
    assign in_frame = (state_q == ST_COLLECT) || (state_q == ST_CHECK);

    cmd_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(rx_valid || !in_frame),
        .en_i (in_frame),
        .tc_o (to_tc)
    );

    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        cmd_data_d  = cmd_data_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        cmd_en_d    = 1'b0;
        strobe_d    = 1'b0;
        err_chk_d   = 1'b0;
        err_to_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    payload_d = {payload_q[39:0], rx_data};
                    sum_d     = sum_q + rx_data;
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == 3'(CMD_BYTES - 1)) begin
                        state_d = ST_CHECK;
                    end
                end else if (to_tc) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        cmd_data_d  = payload_q;
                        cmd_en_d    = 1'b1;
                        strobe_d    = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        hold_d      = '0;
                        state_d     = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (to_tc) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // The entry edge already provided the first enable cycle.
                if (hold_q == 8'(HOLD_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d   = hold_q + 8'd1;
                    cmd_en_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            payload_q   <= '0;
            cmd_data_q  <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            frame_cnt_q <= '0;
            cmd_en_q    <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_chk_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            cmd_data_q  <= cmd_data_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            frame_cnt_q <= frame_cnt_d;
            cmd_en_q    <= cmd_en_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            err_chk_q   <= err_chk_d;
            err_to_q    <= err_to_d;
        end
    end

    assign cmd_data    = cmd_data_q;
    assign cmd_en      = cmd_en_q;
    assign cmd_strobe  = strobe_q;
    assign busy        = busy_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_to_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Scoreboard bench for cmd_frame_ctrl: expected events queued at drive time, popped when the DUT pulses.
module tb_cmd_frame_ctrl;

    localparam int TO = 20;
    localparam int HC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [47:0] cmd_data;
    logic        cmd_en;
    logic        cmd_strobe;
    logic        busy;
    logic        err_chk;
    logic        err_timeout;
    logic [7:0]  frame_cnt;

    cmd_frame_ctrl #(
        .HEADER     (8'hAA),
        .TIMEOUT_CYC(TO),
        .HOLD_CYC   (HC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_data   (cmd_data),
        .cmd_en     (cmd_en),
        .cmd_strobe (cmd_strobe),
        .busy       (busy),
        .err_chk    (err_chk),
        .err_timeout(err_timeout),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // kind: 0 = good frame strobe, 1 = checksum error, 2 = timeout
    typedef struct {
        int          kind;
        logic [47:0] data;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [47:0] m_data = '0;
    logic [7:0]  m_cnt = '0;
    int          run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, cmd_data, 0);
        chk({tag, "_en"}, cmd_en, 0);
        chk({tag, "_strobe"}, cmd_strobe, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_errchk"}, err_chk, 0);
        chk({tag, "_errto"}, err_timeout, 0);
        chk({tag, "_cnt"}, frame_cnt, 0);
    endtask

    // Monitor: sampled 1 time unit after each active edge.
    always begin : mon
        exp_t e;
        int   kind;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            run = 0;
        end else begin
            if (cmd_en) begin
                run++;
            end else if (run != 0) begin
                chk("hold_len", run, HC);
                run = 0;
            end
            if (cmd_strobe || err_chk || err_timeout) begin
                chk("excl", $countones({cmd_strobe, err_chk, err_timeout}), 1);
                kind = cmd_strobe ? 0 : (err_chk ? 1 : 2);
                if (sbq.size() == 0) begin
                    chk("unexpected_event", kind + 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("ev_kind", kind, e.kind);
                    chk("ev_cyc", cyc, e.cyc);
                    chk("ev_data", cmd_data, e.data);
                    chk("ev_cnt", frame_cnt, e.cnt);
                    if (kind == 0) chk("ev_en", cmd_en, 1);
                end
            end
        end
    end

    // Drive one byte after `idle` extra idle cycles; optionally queue an event whose
    // cycle field is an offset from this byte's acceptance edge.
    task automatic send_b(input logic [7:0] b, input int idle = 0,
                          input bit push = 1'b0, input exp_t e = '{0, 48'h0, 8'h0, 0});
        repeat (idle) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (push) begin
            e.cyc = cyc + 1 + e.cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] pl, input logic [7:0] cs);
        logic [7:0] s;
        exp_t       e;
        s = 8'h00;
        for (int i = 0; i < 6; i++) s = s + pl[47-8*i -: 8];
        if (cs == s) begin
            m_cnt  = m_cnt + 8'd1;
            m_data = pl;
            e = '{0, pl, m_cnt, 0};
        end else begin
            e = '{1, m_data, m_cnt, 0};
        end
        send_b(8'hAA);
        for (int i = 0; i < 6; i++) send_b(pl[47-8*i -: 8]);
        send_b(cs, 0, 1'b1, e);
    endtask

    task automatic gap();
        repeat (HC + 3) @(negedge clk);
    endtask

    task automatic do_reset_check(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero(tag);
        m_cnt  = '0;
        m_data = '0;
        rst_n  = 1'b1;
    endtask

    initial begin
        exp_t       e;
        logic [47:0] pl;
        logic [7:0]  s;

        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;

        // Good frame
        send_frame(48'h010203040506, 8'h15);
        gap();
        chk("good_cnt", frame_cnt, 1);

        // Bad checksum, then a good frame is still accepted
        send_frame(48'h010203040506, 8'h16);
        gap();
        chk("bad_busy", busy, 0);
        send_frame(48'h0A0B0C0D0E0F, 8'h4B);
        gap();

        // Junk bytes and header value inside the payload
        send_b(8'h55);
        send_b(8'h00);
        send_frame(48'hAA0000000000, 8'hAA);
        gap();
        chk("junk_data", cmd_data, 48'hAA0000000000);

        // Timeout after AA 01
        send_b(8'hAA);
        chk("busy_collect", busy, 1);
        e = '{2, m_data, m_cnt, TO};
        send_b(8'h01, 0, 1'b1, e);
        repeat (TO + 5) @(negedge clk);
        chk("to_busy", busy, 0);
        send_frame(48'h112233445566, 8'h65);
        gap();

        // Byte exactly at terminal count is accepted
        send_b(8'hAA);
        send_b(8'h01);
        send_b(8'h02, TO - 2);
        for (int i = 3; i <= 6; i++) send_b(8'(i));
        m_cnt  = m_cnt + 8'd1;
        m_data = 48'h010203040506;
        e = '{0, m_data, m_cnt, 0};
        send_b(8'h15, 0, 1'b1, e);
        gap();

        // One cycle later is a timeout; the late byte lands in IDLE and is dropped
        send_b(8'hAA);
        e = '{2, m_data, m_cnt, TO};
        send_b(8'h01, 0, 1'b1, e);
        send_b(8'h02, TO - 1);
        repeat (TO + 5) @(negedge clk);

        // Reset during COLLECT byte 3
        send_b(8'hAA);
        send_b(8'h01);
        send_b(8'h02);
        @(negedge clk);
        rx_data  = 8'h03;
        rx_valid = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        chk_zero("rst_collect");
        m_cnt  = '0;
        m_data = '0;
        rst_n  = 1'b1;
        send_frame(48'h010203040506, 8'h15);
        gap();
        chk("post_rst_cnt", frame_cnt, 1);

        // Reset during HOLD
        send_frame(48'h0000000000FF, 8'hFF);
        @(negedge clk);
        chk("in_hold_en", cmd_en, 1);
        do_reset_check("rst_hold");
        repeat (3) @(negedge clk);

        // Back-to-back: header during HOLD is dropped, third frame accepted
        send_frame(48'h010203040506, 8'h15);
        send_b(8'hAA);
        for (int i = 1; i <= 6; i++) send_b(8'(i));
        send_b(8'h15);
        gap();
        chk("b2b_cnt", frame_cnt, 1);
        send_frame(48'h060504030201, 8'h15);
        gap();
        chk("b2b_cnt3", frame_cnt, 2);

        // 256 good frames from reset wrap the counter to 0
        do_reset_check("rst_wrap");
        for (int n = 0; n < 256; n++) begin
            pl = {$urandom, $urandom};
            s  = 8'h00;
            for (int i = 0; i < 6; i++) s = s + pl[47-8*i -: 8];
            send_frame(pl, s);
            gap();
        end
        chk("wrap_cnt", frame_cnt, 0);
        chk("wrap_data", cmd_data, m_data);

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmd_frame_ctrl.md
Name: cmd_frame_ctrl

Overview:
- Sequences the 48-bit instruction decomposer: assembles a 6-byte command from a UART receive byte stream, validates it, and drives the decomposer's data bus and enable.
- Frame format is 8 bytes: header byte, payload bytes 1..6, checksum byte.
- Sits between the UART receiver and the instruction decomposer in the command path.
- Rejects malformed or stalled frames and reports them with error pulses.

Parameters:
- HEADER, 8'hAA, frame start byte.
- TIMEOUT_CYC, 50000, maximum number of idle clk cycles allowed between consecutive bytes inside a frame; range 2..2^24-1.
- HOLD_CYC, 4, number of clk cycles cmd_en stays high per accepted frame; range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- cmd_data  out  48  assembled payload; payload byte 1 is in [47:40], byte 6 is in [7:0].
- cmd_en  out  1  enable to the decomposer; high for HOLD_CYC cycles per good frame.
- cmd_strobe  out  1  one-cycle pulse on the first cycle of each cmd_en window.
- busy  out  1  high in every state except IDLE.
- err_chk  out  1  one-cycle pulse on checksum mismatch.
- err_timeout  out  1  one-cycle pulse on inter-byte timeout.
- frame_cnt  out  8  count of good frames; wraps from 255 to 0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - cmd_data, frame_cnt, the payload shift register, the byte index, the timeout counter and the hold counter all go to 0.
  - cmd_en, cmd_strobe, busy, err_chk and err_timeout go to 0.
  - Reset mid-frame or mid-hold aborts immediately; no error pulse is generated.
- State IDLE:
  - rx_valid with rx_data==HEADER moves to COLLECT and clears the byte index and timeout counter.
  - Any other byte is discarded silently.
- State COLLECT:
  - Each rx_valid shifts rx_data into the payload register, first byte at the MSB end.
  - The running checksum is updated as an 8-bit sum mod 256.
  - The byte index increments and the timeout counter clears.
  - After the 6th payload byte, move to CHECK.
  - A byte equal to HEADER is payload here; there is no resynchronisation.
- State CHECK:
  - On rx_valid, compare rx_data with the 8-bit sum of the six payload bytes.
  - On match: on the next edge cmd_data is loaded, cmd_en goes to 1, cmd_strobe pulses, frame_cnt increments, and the state moves to HOLD.
  - On mismatch: err_chk pulses for 1 cycle, the state returns to IDLE, and cmd_data is unchanged.
- Latency: cmd_en rises 1 clk after the cycle in which the checksum byte is accepted.
- Timeout (COLLECT and CHECK only):
  - The counter increments on every cycle without rx_valid.
  - When it reaches TIMEOUT_CYC-1 with no rx_valid in that cycle: err_timeout pulses, the partial frame is discarded, and the state returns to IDLE.
  - If rx_valid arrives in the same cycle as the terminal count, the byte is accepted and no timeout occurs.
- State HOLD:
  - cmd_en stays at 1 for exactly HOLD_CYC cycles, then the state returns to IDLE with cmd_en=0.
  - Bytes arriving during HOLD are dropped, including HEADER.
  - cmd_data holds its last good value and is never cleared except by reset.
- Error pulses are mutually exclusive; at most one of err_chk, err_timeout and cmd_strobe is high in any cycle.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package (cmd_pkg) holds:
  - state encoding IDLE=0, COLLECT=1, CHECK=2, HOLD=3;
  - CMD_BYTES=6;
  - the default HEADER constant.
- The timeout counter width is derived as clog2(TIMEOUT_CYC).
- One natural sub-module, cmd_timeout_cnt: a clear/enable counter with a terminal-count flag. The rest is a single FSM.

Test Plan:
- Good frame: AA 01 02 03 04 05 06 15 -> cmd_data=48'h010203040506; cmd_en high 4 cycles starting 1 clk after the byte 15; cmd_strobe pulses once; frame_cnt=1.
- Bad checksum: AA 01 02 03 04 05 06 16 -> err_chk pulses once; cmd_en stays 0; cmd_data unchanged; state back in IDLE, checked by a following good frame being accepted.
- Junk and in-payload header: 55 00 AA AA 00 00 00 00 00 AA -> leading 55 and 00 ignored; payload AA0000000000 accepted; cmd_en asserted.
- Timeout: with TIMEOUT_CYC=20, send AA 01 then stall -> err_timeout pulses on cycle 20 after the 01; a frame sent afterwards succeeds. Also a byte arriving exactly at the terminal count is accepted with no error.
- Reset mid-operation: rst_n=0 during COLLECT byte 3, and separately during HOLD -> all outputs 0 next edge; no error pulses; frame_cnt=0.
- Back-to-back frames: second header arrives during HOLD and is dropped -> only the first frame is counted; a third frame sent after HOLD is accepted; 256 good frames wrap frame_cnt to 0.
